regfile_scoreboard: RTL and testbench

- Architectural register file (32 × 32-bit) combined with a per-register pending-write scoreboard and an operand bypass network.
- Sits beside the read-operands stage. That stage drives `r1_addr`/`r2_addr`; this block returns `r1_valid`/`r1_data` and `r2_valid`/`r2_data`.
- An operand is valid only when no older in-flight write is outstanding, or when that write's result can be forwarded from EX, MEM or WB.

---
 rtl/regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Purpose:
//   32 x 32-bit architectural register file with a per-register pending-write
//   scoreboard and an operand bypass network for the read-operands stage.
//   Each register 1..31 has a saturating counter of in-flight writers. A read
//   of a register with writers in flight is resolved from the youngest
//   matching pipeline stage (EX, then MEM, then WB). A read of a register with
//   no writers in flight comes straight from the register file.
//
// Configuration:
//   RF_FWD_EN - when defined, EX and MEM results are forwarded to the read
//               ports. When undefined, only the WB value is bypassed, and a
//               read of a pending register is valid only on a WB match.
//               The scoreboard and the WB bypass are the same in both builds.
//
// Parameters:
//   CNT_W       width of each pending counter (must hold EX+MEM+WB = 3)
//
// Ports:
//   clk                     clock
//   resetn                  synchronous active-low reset (regs and counters to 0)
//   flush                   clears every counter next cycle; WB write completes
//   r1_addr/r2_addr         read-port register indices
//   r1_valid/r2_valid       operand available this cycle
//   r1_data/r2_data         operand value
//   issue_valid/issue_we    instruction leaves read-operands / writes a register
//   issue_dest              destination of the issuing instruction
//   ex_we/ex_dest           EX-stage writer and its destination
//   ex_data_ok/ex_data      EX result is final / EX result
//   mem_we/mem_dest         MEM-stage writer and its destination
//   mem_data_ok/mem_data    MEM result is final / MEM result
//   wb_we/wb_dest/wb_data   write-back commit
//   issue_full              issuing destination's counter is saturated
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [4:0]  r1_addr,
    input  logic [4:0]  r2_addr,
    output logic        r1_valid,
    output logic [31:0] r1_data,
    output logic        r2_valid,
    output logic [31:0] r2_data,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_dest,
    input  logic        ex_we,
    input  logic [4:0]  ex_dest,
    input  logic        ex_data_ok,
    input  logic [31:0] ex_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_dest,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        issue_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Register file storage. Register 0 is never written, so it stays 0 after
    // reset; the read path forces it to 0 anyway.
    // -------------------------------------------------------------------------
    logic [31:0] regs_reg [32];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_we && (wb_dest != 5'd0)) begin
            regs_reg[wb_dest] <= wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard: one saturating counter per register. All counters are
    // collected into a flat packed vector so the read and issue paths can
    // index them with a run-time register number.
    // -------------------------------------------------------------------------
    logic [32*CNT_W-1:0] pend_flat;
    logic [31:0]         pend_nz;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                // x0 is never tracked: it is always readable.
                assign pend_flat[gi*CNT_W +: CNT_W] = '0;
                assign pend_nz[gi]                  = 1'b0;
            end else begin : g_cnt
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;
                logic             inc;
                logic             dec;

                assign inc = issue_valid && issue_we && (issue_dest == 5'(gi));
                assign dec = wb_we && (wb_dest == 5'(gi));

                // Issue into a saturated counter holds it rather than wrapping,
                // and a retire with nothing pending leaves it at zero; both are
                // protocol errors by the pipeline, so the counter only protects
                // itself. A simultaneous issue and retire cancel out.
                always_comb begin
                    cnt_next = cnt_reg;
                    if (flush) begin
                        cnt_next = '0;
                    end else if (inc && !dec) begin
                        if (cnt_reg != CNT_MAX) begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end else if (dec && !inc) begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (!resetn) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign pend_flat[gi*CNT_W +: CNT_W] = cnt_reg;
                assign pend_nz[gi]                  = |cnt_reg;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Issue back-pressure. Deliberately independent of issue_valid so the
    // read-operands stage can look at it before deciding to issue.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] issue_cnt;

    assign issue_cnt  = pend_flat[int'(issue_dest)*CNT_W +: CNT_W];
    assign issue_full = issue_we && (issue_cnt == CNT_MAX);

    // -------------------------------------------------------------------------
    // Read ports. Both ports share the same resolution logic; port 0 is r1,
    // port 1 is r2. The counter consulted is the current (pre-update) value,
    // so an instruction issuing this cycle never blocks its own sources.
    // -------------------------------------------------------------------------
    logic [1:0]       rd_valid;
    logic [1:0][31:0] rd_data;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [4:0]  addr;
            logic        valid_c;
            logic [31:0] data_c;
            logic        hit_wb;

            assign addr   = (gi == 0) ? r1_addr : r2_addr;
            assign hit_wb = wb_we && (wb_dest == addr);

`ifdef RF_FWD_EN
            logic hit_ex;
            logic hit_mem;

            assign hit_ex  = ex_we && (ex_dest == addr);
            assign hit_mem = mem_we && (mem_dest == addr);

            // Youngest writer wins: EX is younger than MEM, MEM than WB.
            always_comb begin
                valid_c = 1'b1;
                data_c  = regs_reg[addr];
                if (addr == 5'd0) begin
                    valid_c = 1'b1;
                    data_c  = '0;
                end else if (pend_nz[addr]) begin
                    if (hit_ex) begin
                        valid_c = ex_data_ok;
                        data_c  = ex_data;
                    end else if (hit_mem) begin
                        valid_c = mem_data_ok;
                        data_c  = mem_data;
                    end else if (hit_wb) begin
                        valid_c = 1'b1;
                        data_c  = wb_data;
                    end else begin
                        // Writer in flight but not visible in any stage.
                        valid_c = 1'b0;
                    end
                end
            end
`else
            // Without EX/MEM forwarding a pending register becomes readable
            // only when its writer reaches WB.
            always_comb begin
                valid_c = 1'b1;
                data_c  = regs_reg[addr];
                if (addr == 5'd0) begin
                    valid_c = 1'b1;
                    data_c  = '0;
                end else if (pend_nz[addr]) begin
                    if (hit_wb) begin
                        valid_c = 1'b1;
                        data_c  = wb_data;
                    end else begin
                        valid_c = 1'b0;
                    end
                end
            end
`endif

            assign rd_valid[gi] = valid_c;
            assign rd_data[gi]  = data_c;
        end
    endgenerate

    assign r1_valid = rd_valid[0];
    assign r1_data  = rd_data[0];
    assign r2_valid = rd_valid[1];
    assign r2_data  = rd_data[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed scenarios for reset, forwarding, saturation, flush and mid-run
// reset, followed by a randomized phase where the bench runs its own small
// in-order pipeline (EX/MEM/WB slots) and predicts each read from the set of
// in-flight writers and an architectural register array.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

`ifdef RF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [4:0]  r1_addr, r2_addr;
    logic        r1_valid, r2_valid;
    logic [31:0] r1_data, r2_data;
    logic        issue_valid, issue_we;
    logic [4:0]  issue_dest;
    logic        ex_we, mem_we, wb_we;
    logic [4:0]  ex_dest, mem_dest, wb_dest;
    logic        ex_data_ok, mem_data_ok;
    logic [31:0] ex_data, mem_data, wb_data;
    logic        issue_full;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard #(.CNT_W(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .r1_addr     (r1_addr),
        .r2_addr     (r2_addr),
        .r1_valid    (r1_valid),
        .r1_data     (r1_data),
        .r2_valid    (r2_valid),
        .r2_data     (r2_data),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_dest  (issue_dest),
        .ex_we       (ex_we),
        .ex_dest     (ex_dest),
        .ex_data_ok  (ex_data_ok),
        .ex_data     (ex_data),
        .mem_we      (mem_we),
        .mem_dest    (mem_dest),
        .mem_data_ok (mem_data_ok),
        .mem_data    (mem_data),
        .wb_we       (wb_we),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .issue_full  (issue_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (edge + 4).
    task automatic settle();
        #3;
    endtask

    task automatic idle();
        resetn      = 1'b1;
        flush       = 1'b0;
        r1_addr     = 5'd0;
        r2_addr     = 5'd0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dest  = 5'd0;
        ex_we       = 1'b0;
        ex_dest     = 5'd0;
        ex_data_ok  = 1'b0;
        ex_data     = 32'd0;
        mem_we      = 1'b0;
        mem_dest    = 5'd0;
        mem_data_ok = 1'b0;
        mem_data    = 32'd0;
        wb_we       = 1'b0;
        wb_dest     = 5'd0;
        wb_data     = 32'd0;
    endtask

    task automatic issue(input logic [4:0] d);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_dest  = d;
    endtask

    // ---------------- reference model for the random phase ----------------
    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } stage_t;

    stage_t      st [3];          // 0 = EX, 1 = MEM, 2 = WB
    logic [31:0] arch [32];
    logic        ok_ex, ok_mem;

    function automatic stage_t bubble();
        stage_t b;
        b.v    = 1'b0;
        b.we   = 1'b0;
        b.dest = 5'($urandom_range(31, 0));
        b.data = $urandom;
        return b;
    endfunction

    function automatic bit writes(input stage_t s, input logic [4:0] a);
        return s.v && s.we && (s.dest == a);
    endfunction

    // Number of instructions in the pipeline that will still write register a.
    function automatic int in_flight(input logic [4:0] a);
        int n = 0;
        for (int k = 0; k < 3; k++) begin
            if (writes(st[k], a)) n++;
        end
        return n;
    endfunction

    task automatic expect_read(input logic [4:0] a, output logic v, output logic [31:0] d);
        v = 1'b1;
        d = arch[a];
        if (a == 5'd0) begin
            d = 32'd0;
        end else if (in_flight(a) > 0) begin
            if (FWD && writes(st[0], a)) begin
                v = ok_ex;
                d = st[0].data;
            end else if (FWD && writes(st[1], a)) begin
                v = ok_mem;
                d = st[1].data;
            end else if (writes(st[2], a)) begin
                d = st[2].data;
            end else begin
                v = 1'b0;
            end
        end
    endtask

    initial begin
        stage_t      cand;
        bit          have_cand;
        bit          want, fl, full_m;
        logic        ev;
        logic [31:0] ed;

        // ---------------- reset ----------------
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle();

        r1_addr = 5'd0; r2_addr = 5'd5;
        issue_we = 1'b1; issue_dest = 5'd5;
        settle();
        check_val("rst_x0_valid", r1_valid, 1);
        check_val("rst_x0_data", r1_data, 0);
        check_val("rst_x5_valid", r2_valid, 1);
        check_val("rst_x5_data", r2_data, 0);
        check_val("rst_issue_full", issue_full, 0);
        tick();

        // ---------------- x5 through the pipeline ----------------
        idle(); issue(5'd5); r2_addr = 5'd5;
        settle();
        check_val("x5_same_cycle_issue_valid", r2_valid, 1);
        check_val("x5_same_cycle_issue_data", r2_data, 0);
        tick();

        idle(); ex_we = 1; ex_dest = 5'd5; ex_data_ok = 0; ex_data = 32'h1234; r1_addr = 5'd5;
        settle();
        check_val("x5_ex_notok_valid", r1_valid, 0);
        check_val("x5_ex_notok_data", r1_data, FWD ? 32'h1234 : 32'h0);
        tick();

        idle(); mem_we = 1; mem_dest = 5'd5; mem_data_ok = 1; mem_data = 32'h1234; r1_addr = 5'd5;
        settle();
        check_val("x5_mem_valid", r1_valid, FWD ? 1 : 0);
        check_val("x5_mem_data", r1_data, FWD ? 32'h1234 : 32'h0);
        tick();

        idle(); wb_we = 1; wb_dest = 5'd5; wb_data = 32'h1234; r1_addr = 5'd5;
        settle();
        check_val("x5_wb_bypass_valid", r1_valid, 1);
        check_val("x5_wb_bypass_data", r1_data, 32'h1234);
        tick();

        idle(); r1_addr = 5'd5;
        settle();
        check_val("x5_regfile_valid", r1_valid, 1);
        check_val("x5_regfile_data", r1_data, 32'h1234);
        tick();

        // ---------------- x3 EX forward ----------------
        idle(); issue(5'd3);
        tick();
        idle(); ex_we = 1; ex_dest = 5'd3; ex_data_ok = 1; ex_data = 32'hAA; r1_addr = 5'd3;
        settle();
        check_val("x3_ex_fwd_valid", r1_valid, FWD ? 1 : 0);
        check_val("x3_ex_fwd_data", r1_data, FWD ? 32'hAA : 32'h0);
        tick();

        // ---------------- x7: ALU in EX younger than load in MEM ----------------
        idle(); issue(5'd7);
        tick();
        idle(); issue(5'd7); ex_we = 1; ex_dest = 5'd7; ex_data_ok = 0; ex_data = 32'h77; r2_addr = 5'd7;
        settle();
        check_val("x7_load_in_ex_valid", r2_valid, 0);
        tick();
        idle();
        ex_we = 1; ex_dest = 5'd7; ex_data_ok = 1; ex_data = 32'h55;
        mem_we = 1; mem_dest = 5'd7; mem_data_ok = 0; mem_data = 32'h77;
        r2_addr = 5'd7;
        settle();
        check_val("x7_youngest_valid", r2_valid, FWD ? 1 : 0);
        check_val("x7_youngest_data", r2_data, FWD ? 32'h55 : 32'h0);
        tick();

        // ---------------- x9 saturation ----------------
        for (int k = 0; k < 3; k++) begin
            idle(); issue(5'd9);
            settle();
            check_val($sformatf("x9_issue%0d_full", k), issue_full, 0);
            tick();
        end
        idle(); issue_we = 1; issue_dest = 5'd9; r1_addr = 5'd9;
        settle();
        check_val("x9_fourth_full", issue_full, 1);
        check_val("x9_pending_nomatch_valid", r1_valid, 0);
        tick();
        idle(); issue(5'd9); wb_we = 1; wb_dest = 5'd9; wb_data = 32'h99; r1_addr = 5'd9;
        settle();
        check_val("x9_issue_wb_full", issue_full, 1);
        check_val("x9_wb_valid", r1_valid, 1);
        check_val("x9_wb_data", r1_data, 32'h99);
        tick();
        idle(); issue_we = 1; issue_dest = 5'd9; r1_addr = 5'd9;
        settle();
        check_val("x9_held_full", issue_full, 1);
        check_val("x9_held_valid", r1_valid, 0);
        check_val("x9_held_data", r1_data, 32'h99);
        tick();

        // ---------------- flush ----------------
        idle(); issue(5'd4); tick();
        idle(); issue(5'd4); tick();
        idle(); issue(5'd6); tick();
        idle(); flush = 1; wb_we = 1; wb_dest = 5'd6; wb_data = 32'h66; r1_addr = 5'd6;
        settle();
        check_val("flush_wb_valid", r1_valid, 1);
        check_val("flush_wb_data", r1_data, 32'h66);
        tick();
        idle(); r1_addr = 5'd4; r2_addr = 5'd6;
        settle();
        check_val("post_flush_x4_valid", r1_valid, 1);
        check_val("post_flush_x4_data", r1_data, 0);
        check_val("post_flush_x6_valid", r2_valid, 1);
        check_val("post_flush_x6_data", r2_data, 32'h66);
        tick();
        idle(); r1_addr = 5'd9; r2_addr = 5'd7; issue_we = 1; issue_dest = 5'd9;
        settle();
        check_val("post_flush_x9_valid", r1_valid, 1);
        check_val("post_flush_x9_data", r1_data, 32'h99);
        check_val("post_flush_x7_valid", r2_valid, 1);
        check_val("post_flush_x9_full", issue_full, 0);
        tick();
        idle(); r1_addr = 5'd3;
        settle();
        check_val("post_flush_x3_valid", r1_valid, 1);
        tick();

        // ---------------- reset in mid-operation ----------------
        idle(); issue(5'd8); tick();
        idle(); issue(5'd8); tick();
        idle(); resetn = 0; issue(5'd8); wb_we = 1; wb_dest = 5'd8; wb_data = 32'h88;
        tick();
        idle(); r1_addr = 5'd8; r2_addr = 5'd5; issue_we = 1; issue_dest = 5'd8;
        settle();
        check_val("midrst_x8_valid", r1_valid, 1);
        check_val("midrst_x8_data", r1_data, 0);
        check_val("midrst_x5_data", r2_data, 0);
        check_val("midrst_x8_full", issue_full, 0);
        tick();
        idle(); r1_addr = 5'd6; r2_addr = 5'd9;
        settle();
        check_val("midrst_x6_data", r1_data, 0);
        check_val("midrst_x9_data", r2_data, 0);
        tick();

        // ---------------- randomized pipeline phase ----------------
        for (int k = 0; k < 32; k++) arch[k] = 32'd0;
        for (int k = 0; k < 3; k++) st[k] = bubble();
        have_cand = 1'b0;
        cand = bubble();

        for (int cyc = 0; cyc < 2000; cyc++) begin
            idle();
            if (!have_cand) begin
                cand.v    = 1'b1;
                cand.we   = ($urandom_range(3, 0) != 0);
                cand.dest = ($urandom_range(3, 0) == 0) ? 5'($urandom_range(31, 0))
                                                        : 5'($urandom_range(5, 0));
                cand.data = $urandom;
                have_cand = 1'b1;
            end
            want   = ($urandom_range(9, 0) < 7);
            fl     = ($urandom_range(24, 0) == 0);
            full_m = cand.we && (cand.dest != 5'd0) && (in_flight(cand.dest) >= 3);
            ok_ex  = $urandom_range(1, 0) == 1;
            ok_mem = $urandom_range(1, 0) == 1;

            flush       = fl;
            issue_valid = want && !full_m;
            issue_we    = cand.we;
            issue_dest  = cand.dest;
            ex_we       = st[0].v && st[0].we;
            ex_dest     = st[0].dest;
            ex_data     = st[0].data;
            ex_data_ok  = ok_ex;
            mem_we      = st[1].v && st[1].we;
            mem_dest    = st[1].dest;
            mem_data    = st[1].data;
            mem_data_ok = ok_mem;
            wb_we       = st[2].v && st[2].we;
            wb_dest     = st[2].dest;
            wb_data     = st[2].data;
            r1_addr     = ($urandom_range(1, 0) == 0) ? 5'($urandom_range(6, 0))
                                                      : 5'($urandom_range(31, 0));
            r2_addr     = 5'($urandom_range(7, 0));
            settle();

            check_val($sformatf("rnd%0d_issue_full", cyc), issue_full, full_m);
            expect_read(r1_addr, ev, ed);
            check_val($sformatf("rnd%0d_r1_valid x%0d", cyc, r1_addr), r1_valid, ev);
            check_val($sformatf("rnd%0d_r1_data x%0d", cyc, r1_addr), r1_data, ed);
            expect_read(r2_addr, ev, ed);
            check_val($sformatf("rnd%0d_r2_valid x%0d", cyc, r2_addr), r2_valid, ev);
            check_val($sformatf("rnd%0d_r2_data x%0d", cyc, r2_addr), r2_data, ed);

            // Advance the model pipeline.
            if (st[2].v && st[2].we && st[2].dest != 5'd0) arch[st[2].dest] = st[2].data;
            st[2] = st[1];
            st[1] = st[0];
            st[0] = issue_valid ? cand : bubble();
            if (issue_valid || fl) have_cand = 1'b0;
            if (fl) begin
                for (int k = 0; k < 3; k++) st[k] = bubble();
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
